// File: rtl/dio_pulse_trigger.sv
// Time-triggered pulse generator for one DIO channel: fires a programmable-length
// pulse when White Rabbit time reaches a latched trigger time.
module dio_pulse_trigger #(
    parameter int g_tai_width    = 40,
    parameter int g_cycles_width = 28,
    parameter int g_len_width    = 28
) (
    input  logic                      clk_ref_i,
    input  logic                      rst_i,
    input  logic [g_tai_width-1:0]    tm_tai_i,
    input  logic [g_cycles_width-1:0] tm_cycles_i,
    input  logic                      tm_time_valid_i,
    input  logic [g_tai_width-1:0]    trig_tai_i,
    input  logic [g_cycles_width-1:0] trig_cycles_i,
    input  logic [g_len_width-1:0]    pulse_len_i,
    input  logic                      arm_i,
    input  logic                      abort_i,
    output logic                      pulse_o,
    output logic                      armed_o,
    output logic                      done_o,
    output logic                      late_o
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARMED,
        ST_PULSE
    } state_t;

    state_t                    r_state;
    logic [g_tai_width-1:0]    r_trig_tai;
    logic [g_cycles_width-1:0] r_trig_cycles;
    logic [g_len_width-1:0]    r_len;
    logic [g_len_width-1:0]    r_cnt;
    logic                      r_pulse;
    logic                      r_armed;
    logic                      r_done;
    logic                      r_late;

    logic                      w_reached;
    logic                      w_arm_late;
    logic                      w_load;
    logic [g_len_width-1:0]    w_len_in;

    // Fire test uses the latched trigger; the late test on arm uses the incoming one.
    assign w_reached  = (tm_tai_i > r_trig_tai) ||
                        ((tm_tai_i == r_trig_tai) && (tm_cycles_i >= r_trig_cycles));
    assign w_arm_late = tm_time_valid_i &&
                        ((tm_tai_i > trig_tai_i) ||
                         ((tm_tai_i == trig_tai_i) && (tm_cycles_i >= trig_cycles_i)));

    // Abort beats arm while armed; arm is ignored once the pulse is running.
    assign w_load   = arm_i && ((r_state == ST_IDLE) || ((r_state == ST_ARMED) && !abort_i));
    assign w_len_in = (pulse_len_i == '0) ? g_len_width'(1) : pulse_len_i;

    // NOTE: every register is in the async reset, so outputs clear without a clock edge.
    always_ff @(posedge clk_ref_i or posedge rst_i) begin
        if (rst_i) begin
            r_trig_tai    <= '0;
            r_trig_cycles <= '0;
            r_len         <= '0;
        end else if (w_load) begin
            r_trig_tai    <= trig_tai_i;
            r_trig_cycles <= trig_cycles_i;
            r_len         <= w_len_in;
        end
    end

    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    always_ff @(posedge clk_ref_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_pulse <= 1'b0;
            r_armed <= 1'b0;
            r_done  <= 1'b0;
            r_late  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_late <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_load) begin
                        if (w_arm_late) begin
                            r_late <= 1'b1;
                        end else begin
                            r_state <= ST_ARMED;
                            r_armed <= 1'b1;
                        end
                    end
                end
                ST_ARMED: begin
                    if (abort_i) begin
                        r_state <= ST_IDLE;
                        r_armed <= 1'b0;
                    end else if (w_load) begin
                        if (w_arm_late) begin
                            r_late  <= 1'b1;
                            r_state <= ST_IDLE;
                            r_armed <= 1'b0;
                        end
                    end else if (tm_time_valid_i && w_reached) begin
                        r_state <= ST_PULSE;
                        r_pulse <= 1'b1;
                        r_armed <= 1'b0;
                        r_cnt   <= r_len;
                    end
                end
                ST_PULSE: begin
                    if (abort_i) begin
                        r_state <= ST_IDLE;
                        r_pulse <= 1'b0;
                    end else if (r_cnt == g_len_width'(1)) begin
                        r_state <= ST_IDLE;
                        r_pulse <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - g_len_width'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_pulse <= 1'b0;
                    r_armed <= 1'b0;
                end
            endcase
        end
    end

    assign pulse_o = r_pulse;
    assign armed_o = r_armed;
    assign done_o  = r_done;
    assign late_o  = r_late;

endmodule

// File: tb/tb_dio_pulse_trigger.sv
// Self-checking bench for dio_pulse_trigger: directed scenarios plus a randomized
// run compared against a timeline-level reference model.
module tb_dio_pulse_trigger;

    localparam longint SEC = 125000000;

    logic        clk;
    logic        rst;
    logic [39:0] tm_tai;
    logic [27:0] tm_cycles;
    logic        tm_valid;
    logic [39:0] trig_tai;
    logic [27:0] trig_cycles;
    logic [27:0] pulse_len;
    logic        arm;
    logic        abort;
    logic        pulse_o;
    logic        armed_o;
    logic        done_o;
    logic        late_o;

    int n_pass  = 0;
    int n_total = 0;
    bit chk_model = 0;

    // Reference model: waiting flag, latched trigger, remaining high cycles.
    bit     m_wait;
    longint m_ttai, m_tcyc, m_len;
    longint m_left;
    bit     e_done, e_late;

    dio_pulse_trigger dut (
        .clk_ref_i       (clk),
        .rst_i           (rst),
        .tm_tai_i        (tm_tai),
        .tm_cycles_i     (tm_cycles),
        .tm_time_valid_i (tm_valid),
        .trig_tai_i      (trig_tai),
        .trig_cycles_i   (trig_cycles),
        .pulse_len_i     (pulse_len),
        .arm_i           (arm),
        .abort_i         (abort),
        .pulse_o         (pulse_o),
        .armed_o         (armed_o),
        .done_o          (done_o),
        .late_o          (late_o)
    );

    initial clk = 1'b0;
    always #4 clk = ~clk;

    function automatic bit reached(longint tai, longint cyc, longint ttai, longint tcyc);
        return (tai > ttai) || ((tai == ttai) && (cyc >= tcyc));
    endfunction

    task automatic model_update();
        longint now_tai = longint'(tm_tai);
        longint now_cyc = longint'(tm_cycles);
        e_done = 1'b0;
        e_late = 1'b0;
        if (rst) begin
            m_wait = 1'b0;
            m_left = 0;
        end else if (m_left > 0) begin
            if (abort)            m_left = 0;
            else if (m_left == 1) begin m_left = 0; e_done = 1'b1; end
            else                  m_left = m_left - 1;
        end else if (m_wait && abort) begin
            m_wait = 1'b0;
        end else if (arm) begin
            m_ttai = longint'(trig_tai);
            m_tcyc = longint'(trig_cycles);
            m_len  = (pulse_len == 0) ? 1 : longint'(pulse_len);
            if (tm_valid && reached(now_tai, now_cyc, m_ttai, m_tcyc)) begin
                e_late = 1'b1;
                m_wait = 1'b0;
            end else begin
                m_wait = 1'b1;
            end
        end else if (m_wait && tm_valid && reached(now_tai, now_cyc, m_ttai, m_tcyc)) begin
            m_wait = 1'b0;
            m_left = m_len;
        end
    endtask

    // One clock: model sees this cycle's inputs, then time advances after the edge.
    task automatic step();
        logic [3:0] exp_v;
        model_update();
        @(posedge clk);
        #1;
        arm   = 1'b0;
        abort = 1'b0;
        if (tm_cycles == 28'd124999999) begin
            tm_cycles = '0;
            tm_tai    = tm_tai + 40'd1;
        end else begin
            tm_cycles = tm_cycles + 28'd1;
        end
        if (chk_model) begin
            exp_v = {m_left > 0, m_wait, e_done, e_late};
            n_total++;
            if ({pulse_o, armed_o, done_o, late_o} !== exp_v)
                $display("FAIL random_model t=%0t: pulse/armed/done/late=%b expected %b",
                         $time, {pulse_o, armed_o, done_o, late_o}, exp_v);
            else n_pass++;
        end
    endtask

    task automatic set_time(input longint tai, input longint cyc);
        tm_tai    = 40'(tai);
        tm_cycles = 28'(cyc);
    endtask

    task automatic arm_with(input longint ttai, input longint tcyc, input longint len);
        arm         = 1'b1;
        trig_tai    = 40'(ttai);
        trig_cycles = 28'(tcyc);
        pulse_len   = 28'(len);
    endtask

    task automatic wait_until(input longint tai, input longint cyc, input int budget,
                              input string name);
        int n = 0;
        while (!(tm_tai == 40'(tai) && tm_cycles == 28'(cyc)) && n < budget) begin
            step();
            n++;
        end
        n_total++;
        if (!(tm_tai == 40'(tai) && tm_cycles == 28'(cyc)))
            $display("FAIL %s: time (%0d,%0d) not reached, at (%0d,%0d)",
                     name, tai, cyc, tm_tai, tm_cycles);
        else n_pass++;
    endtask

    // Counts high samples starting from a sample where pulse_o is already high.
    task automatic measure_high(input int maxc, output int w);
        w = 0;
        while (pulse_o === 1'b1 && w < maxc) begin
            w++;
            step();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_total++;
        if ({pulse_o, armed_o, done_o, late_o} !== 4'b0000)
            $display("FAIL reset_outputs: got %b expected 0000", {pulse_o, armed_o, done_o, late_o});
        else n_pass++;
        rst = 1'b0;
        repeat (3) step();
        n_total++;
        if ({pulse_o, armed_o, done_o, late_o} !== 4'b0000)
            $display("FAIL reset_release_idle: got %b expected 0000", {pulse_o, armed_o, done_o, late_o});
        else n_pass++;
    endtask

    task automatic test_basic();
        int w;
        set_time(10, 1000);
        arm_with(10, 5000, 16);
        step();
        n_total++;
        if (armed_o !== 1'b1 || pulse_o !== 1'b0)
            $display("FAIL basic_armed: armed=%b pulse=%b expected 1 0", armed_o, pulse_o);
        else n_pass++;
        wait_until(10, 5000, 5000, "basic_wait");
        n_total++;
        if (pulse_o !== 1'b0 || armed_o !== 1'b1)
            $display("FAIL basic_prefire: pulse=%b armed=%b expected 0 1", pulse_o, armed_o);
        else n_pass++;
        step();
        n_total++;
        if (pulse_o !== 1'b1 || armed_o !== 1'b0)
            $display("FAIL basic_rise: pulse=%b armed=%b expected 1 0", pulse_o, armed_o);
        else n_pass++;
        measure_high(100, w);
        n_total++;
        if (w != 16) $display("FAIL basic_width: got %0d expected 16", w);
        else n_pass++;
        n_total++;
        if (done_o !== 1'b1) $display("FAIL basic_done: done=%b expected 1", done_o);
        else n_pass++;
        step();
        n_total++;
        if (done_o !== 1'b0) $display("FAIL basic_done_strobe: done=%b expected 0", done_o);
        else n_pass++;
    endtask

    task automatic test_late();
        bit bad = 0;
        set_time(10, 1000);
        arm_with(10, 500, 5);
        step();
        n_total++;
        if (late_o !== 1'b1 || armed_o !== 1'b0)
            $display("FAIL late_past: late=%b armed=%b expected 1 0", late_o, armed_o);
        else n_pass++;
        step();
        n_total++;
        if (late_o !== 1'b0) $display("FAIL late_strobe: late=%b expected 0", late_o);
        else n_pass++;
        arm_with(longint'(tm_tai), longint'(tm_cycles), 5);
        step();
        n_total++;
        if (late_o !== 1'b1 || armed_o !== 1'b0)
            $display("FAIL late_equal: late=%b armed=%b expected 1 0", late_o, armed_o);
        else n_pass++;
        for (int i = 0; i < 20; i++) begin
            step();
            if (pulse_o !== 1'b0 || armed_o !== 1'b0) bad = 1;
        end
        n_total++;
        if (bad) $display("FAIL late_quiet: pulse/armed rose after late arm, expected 0");
        else n_pass++;
    endtask

    task automatic test_wrap();
        int w;
        set_time(10, 124999990);
        arm_with(11, 3, 0);
        step();
        n_total++;
        if (armed_o !== 1'b1) $display("FAIL wrap_armed: armed=%b expected 1", armed_o);
        else n_pass++;
        wait_until(11, 3, 100, "wrap_wait");
        n_total++;
        if (pulse_o !== 1'b0) $display("FAIL wrap_prefire: pulse=%b expected 0", pulse_o);
        else n_pass++;
        step();
        n_total++;
        if (pulse_o !== 1'b1) $display("FAIL wrap_rise: pulse=%b expected 1", pulse_o);
        else n_pass++;
        step();
        n_total++;
        if (pulse_o !== 1'b0 || done_o !== 1'b1)
            $display("FAIL wrap_len0: pulse=%b done=%b expected 0 1", pulse_o, done_o);
        else n_pass++;
        // Trigger cycle beyond the last cycle of a second fires at the next second.
        set_time(10, 124999995);
        arm_with(10, 125000005, 2);
        step();
        n_total++;
        if (armed_o !== 1'b1 || late_o !== 1'b0)
            $display("FAIL ovf_armed: armed=%b late=%b expected 1 0", armed_o, late_o);
        else n_pass++;
        wait_until(11, 0, 100, "ovf_wait");
        n_total++;
        if (pulse_o !== 1'b0) $display("FAIL ovf_prefire: pulse=%b expected 0", pulse_o);
        else n_pass++;
        step();
        n_total++;
        if (pulse_o !== 1'b1) $display("FAIL ovf_rise: pulse=%b expected 1", pulse_o);
        else n_pass++;
        measure_high(20, w);
        n_total++;
        if (w != 2) $display("FAIL ovf_width: got %0d expected 2", w);
        else n_pass++;
    endtask

    task automatic test_valid();
        int  w;
        bit  bad = 0;
        int  n = 0;
        set_time(20, 50);
        tm_valid = 1'b1;
        arm_with(20, 100, 8);
        step();
        tm_valid = 1'b0;
        while (!(tm_tai == 40'd20 && tm_cycles == 28'd200) && n < 500) begin
            step();
            n++;
            if (pulse_o !== 1'b0 || armed_o !== 1'b1) bad = 1;
        end
        n_total++;
        if (bad || tm_cycles != 28'd200)
            $display("FAIL valid_hold: fired or disarmed while time invalid (cycles=%0d) expected hold to 200",
                     tm_cycles);
        else n_pass++;
        tm_valid = 1'b1;
        step();
        n_total++;
        if (pulse_o !== 1'b1 || armed_o !== 1'b0)
            $display("FAIL valid_fire: pulse=%b armed=%b expected 1 0", pulse_o, armed_o);
        else n_pass++;
        tm_valid = 1'b0;
        measure_high(50, w);
        tm_valid = 1'b1;
        n_total++;
        if (w != 8) $display("FAIL valid_width: got %0d expected 8", w);
        else n_pass++;
    endtask

    task automatic test_abort();
        bit bad = 0;
        set_time(10, 1000);
        arm_with(10, 1010, 1000);
        step();
        wait_until(10, 1010, 50, "abort_wait");
        step();
        n_total++;
        if (pulse_o !== 1'b1) $display("FAIL abort_rise: pulse=%b expected 1", pulse_o);
        else n_pass++;
        repeat (99) step();
        arm_with(10, 0, 5);
        step();
        n_total++;
        if (late_o !== 1'b0 || pulse_o !== 1'b1)
            $display("FAIL pulse_ignores_arm: late=%b pulse=%b expected 0 1", late_o, pulse_o);
        else n_pass++;
        for (int i = 0; i < 198; i++) begin
            step();
            if (pulse_o !== 1'b1) bad = 1;
        end
        n_total++;
        if (bad) $display("FAIL abort_prehold: pulse dropped early, expected 1");
        else n_pass++;
        abort = 1'b1;
        step();
        n_total++;
        if (pulse_o !== 1'b0 || done_o !== 1'b0)
            $display("FAIL abort_cut: pulse=%b done=%b expected 0 0", pulse_o, done_o);
        else n_pass++;
        step();
        n_total++;
        if (done_o !== 1'b0 || armed_o !== 1'b0)
            $display("FAIL abort_idle: done=%b armed=%b expected 0 0", done_o, armed_o);
        else n_pass++;
        arm_with(11, 0, 4);
        step();
        arm_with(12, 0, 4);
        abort = 1'b1;
        step();
        n_total++;
        if (armed_o !== 1'b0 || late_o !== 1'b0)
            $display("FAIL abort_wins: armed=%b late=%b expected 0 0", armed_o, late_o);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        bit bad = 0;
        set_time(30, 0);
        arm_with(30, 5, 50);
        step();
        wait_until(30, 5, 20, "arst_wait");
        step();
        n_total++;
        if (pulse_o !== 1'b1) $display("FAIL arst_rise: pulse=%b expected 1", pulse_o);
        else n_pass++;
        repeat (3) step();
        #2;
        rst = 1'b1;
        #1;
        n_total++;
        if ({pulse_o, armed_o, done_o, late_o} !== 4'b0000)
            $display("FAIL arst_immediate: got %b expected 0000", {pulse_o, armed_o, done_o, late_o});
        else n_pass++;
        repeat (2) step();
        rst = 1'b0;
        for (int i = 0; i < 60; i++) begin
            step();
            if (pulse_o !== 1'b0 || armed_o !== 1'b0 || done_o !== 1'b0) bad = 1;
        end
        n_total++;
        if (bad) $display("FAIL arst_stay_idle: activity without arm, expected none");
        else n_pass++;
        arm_with(30, longint'(tm_cycles) + 5, 3);
        step();
        n_total++;
        if (armed_o !== 1'b1) $display("FAIL arst_rearm: armed=%b expected 1", armed_o);
        else n_pass++;
        repeat (12) step();
    endtask

    task automatic test_random();
        longint cur, tgt;
        int     off;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        m_wait = 1'b0;
        m_left = 0;
        set_time(5, 124998500);
        tm_valid  = 1'b1;
        chk_model = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            int r = int'($urandom_range(0, 99));
            if (r < 3) begin
                cur = longint'(tm_tai) * SEC + longint'(tm_cycles);
                off = int'($urandom_range(0, 260)) - 60;
                tgt = cur + off;
                arm_with(tgt / SEC, tgt % SEC, longint'($urandom_range(0, 12)));
            end else if (r < 4) begin
                abort = 1'b1;
            end
            if ($urandom_range(0, 99) == 0) tm_valid = ~tm_valid;
            step();
        end
        chk_model = 1'b0;
        tm_valid  = 1'b1;
    endtask

    initial begin
        rst         = 1'b1;
        tm_tai      = '0;
        tm_cycles   = '0;
        tm_valid    = 1'b1;
        trig_tai    = '0;
        trig_cycles = '0;
        pulse_len   = '0;
        arm         = 1'b0;
        abort       = 1'b0;
        m_wait      = 1'b0;
        m_left      = 0;
        m_ttai      = 0;
        m_tcyc      = 0;
        m_len       = 1;
        test_reset();
        test_basic();
        test_late();
        test_wrap();
        test_valid();
        test_abort();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_total);
        $fatal(1, "watchdog expired");
    end

endmodule
